l2_fwd_stall_buf: RTL
=====================

L2_FWD_STALL_BUF -- requirements
Module: l2_fwd_stall_buf

Interface
REQ-001 Parameter N_FWD_STALL, default 4: number of stalled-forward entries.
REQ-002 Parameter FWD_STALL_BITS, default 2: log2(N_FWD_STALL), width of entry indices.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 fwd_in_valid  in  1  a forward is offered for stalling.
REQ-006 fwd_in_ready  out  1  buffer accepts the forward; equals !full.
REQ-007 fwd_in_coh_msg  in  mix_msg_t  forward message type.
REQ-008 fwd_in_addr  in  line_addr_t  forward line address.
REQ-009 fwd_in_req_id  in  cache_id_t  requester of the forward.
REQ-010 fwd_in_word_mask  in  word_mask_t  forward word mask.
REQ-011 fwd_in_wait_i  in  REQS_BITS  index of the request-buffer entry the forward waits on.
REQ-012 req_done_valid  in  1  a request-buffer entry returns to INVALID this cycle.
REQ-013 req_done_i  in  REQS_BITS  index of that entry.
REQ-014 fwd_out_valid  out  1  a released forward is presented for replay.
REQ-015 fwd_out_ready  in  1  the consumer takes the replayed forward.
REQ-016 fwd_out_coh_msg, fwd_out_addr, fwd_out_req_id, fwd_out_word_mask  out  same types as inputs  replayed forward fields.
REQ-017 full  out  1  count == N_FWD_STALL.
REQ-018 empty  out  1  count == 0.
REQ-019 count  out  FWD_STALL_BITS+1  number of occupied entries.

Function
REQ-020 Storage SHALL be an arrival-ordered array: entry 0 is oldest; occupied entries are 0..count-1; each entry holds the fields, wait_i and a pending bit.
REQ-021 Push SHALL occur when fwd_in_valid && fwd_in_ready; the entry is written at position count (after the same-cycle pop compaction) with pending=1.
REQ-022 A push whose fwd_in_wait_i equals req_done_i while req_done_valid is high in the same cycle SHALL be written with pending=0.
REQ-023 When req_done_valid is high, every occupied entry with pending=1 and wait_i == req_done_i SHALL clear pending at the next edge; entries waiting on other indices are unchanged.
REQ-024 Selection: when no entry is locked, the oldest occupied entry with pending=0 SHALL become locked at the next edge, and fwd_out_valid SHALL assert from that edge; minimum latency from release to fwd_out_valid is 1 cycle.
REQ-025 While fwd_out_valid=1 and fwd_out_ready=0, the locked entry and all fwd_out_* fields SHALL remain stable, even if an older entry is released.
REQ-026 Pop SHALL occur when fwd_out_valid && fwd_out_ready; the locked entry is removed, younger entries shift down by one, count decrements, and the lock clears.
REQ-027 A new selection MAY lock in the cycle after a pop; back-to-back replays SHALL therefore sustain one pop per two cycles, minimum.
REQ-028 A simultaneous push and pop SHALL leave count unchanged; fwd_in_ready SHALL reflect the registered full only, with no same-cycle bypass when full.
REQ-029 Forwards to the same line waiting on the same wait_i SHALL replay in arrival order.
REQ-030 fwd_in_valid while full SHALL be ignored, leaving state unchanged; the sender holds the forward.
REQ-031 req_done_valid matching no pending entry SHALL have no effect.

Reset
REQ-032 With rst low at an edge: count=0, all pending=0, lock cleared, fwd_out_valid=0, fwd_out_* fields=0, fwd_in_ready=1, full=0, empty=1.
REQ-033 Reset asserted mid-operation SHALL discard all entries, including a locked, unaccepted forward; no replay follows.

Structure
REQ-034 mix_msg_t, line_addr_t, cache_id_t, word_mask_t, REQS_BITS and N_REQS come from the shared spandex_types/spandex_consts package; N_FWD_STALL and FWD_STALL_BITS are added there as defaults.
REQ-035 A fwd_stall_entry_t struct (fields, wait_i, pending) SHALL be defined in the shared package.
REQ-036 The block is a single module; an oldest-ready priority picker is the only natural sub-block and stays inline.

Verification
REQ-037 Push 3 forwards, each with wait_i=2, then req_done_i=2 -> 3 replays in arrival order; fwd_out_valid first asserts 1 cycle after req_done.
REQ-038 Push A(wait 1), B(wait 3); req_done 3 then 1 -> B replays first, then A; count goes 2→1→0.
REQ-039 Fill 4 entries -> full=1, fwd_in_ready=0; a 5th fwd_in_valid is ignored; one pop -> fwd_in_ready=1 next cycle.
REQ-040 Lock B with fwd_out_ready=0 for 5 cycles, releasing older A meanwhile -> B fields stable throughout; A replays after B.
REQ-041 Push with fwd_in_wait_i=0 while req_done_valid=1 and req_done_i=0 -> entry enters with pending=0 and replays without a further req_done.
REQ-042 Assert rst while an entry is locked and count=3 -> next cycle count=0, empty=1, fwd_out_valid=0.

Source files
------------

// File: rtl/l2_fwd_stall_buf_pkg.sv
// Shared L2 types and constants used by the forward stall buffer.
// Provides the coherence message, line address, cache id and word mask
// types, the request-buffer index width, the default stall-buffer geometry,
// the stalled-forward entry struct and a small wait-match helper.
package l2_fwd_stall_buf_pkg;

    localparam int ADDR_BITS        = 32;
    localparam int LINE_OFFSET_BITS = 4;
    localparam int LINE_ADDR_BITS   = ADDR_BITS - LINE_OFFSET_BITS;
    localparam int MIX_MSG_BITS     = 3;
    localparam int CACHE_ID_BITS    = 4;
    localparam int WORDS_PER_LINE   = 4;
    localparam int REQS_BITS        = 2;
    localparam int N_REQS           = 4;

    // Default stall-buffer geometry; the buffer module may override these.
    localparam int DEFAULT_N_FWD_STALL    = 4;
    localparam int DEFAULT_FWD_STALL_BITS = 2;

    typedef logic [MIX_MSG_BITS-1:0]   mix_msg_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [CACHE_ID_BITS-1:0]  cache_id_t;
    typedef logic [WORDS_PER_LINE-1:0] word_mask_t;
    typedef logic [REQS_BITS-1:0]      reqs_idx_t;

    // One stalled forward: its fields, the request entry it waits on, and
    // whether that request is still outstanding.
    typedef struct packed {
        mix_msg_t   coh_msg;
        line_addr_t addr;
        cache_id_t  req_id;
        word_mask_t word_mask;
        reqs_idx_t  wait_i;
        logic       pending;
    } fwd_stall_entry_t;

    // True when a request-done event releases a forward waiting on wait_i.
    function automatic logic done_hit(
        input reqs_idx_t wait_i,
        input logic      done_valid,
        input reqs_idx_t done_i
    );
        return done_valid && (wait_i == done_i);
    endfunction

endpackage

// File: rtl/l2_fwd_stall_buf.sv
// Stalled-forward buffer for the L2.
// Forwards that hit a line with an outstanding request are parked here in
// arrival order together with the request-buffer index they wait on. When
// that request completes, the forward becomes ready; the oldest ready entry
// is locked and presented for replay until the consumer accepts it.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   fwd_in_*                  forward offered for stalling (valid/ready)
//   req_done_valid/_i         a request-buffer entry completed
//   fwd_out_*                 locked forward presented for replay
//   full, empty, count        occupancy status
module l2_fwd_stall_buf
    import l2_fwd_stall_buf_pkg::*;
#(
    parameter int N_FWD_STALL    = DEFAULT_N_FWD_STALL,
    parameter int FWD_STALL_BITS = DEFAULT_FWD_STALL_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fwd_in_valid,
    output logic                    fwd_in_ready,
    input  mix_msg_t                fwd_in_coh_msg,
    input  line_addr_t              fwd_in_addr,
    input  cache_id_t               fwd_in_req_id,
    input  word_mask_t              fwd_in_word_mask,
    input  reqs_idx_t               fwd_in_wait_i,
    input  logic                    req_done_valid,
    input  reqs_idx_t               req_done_i,
    output logic                    fwd_out_valid,
    input  logic                    fwd_out_ready,
    output mix_msg_t                fwd_out_coh_msg,
    output line_addr_t              fwd_out_addr,
    output cache_id_t               fwd_out_req_id,
    output word_mask_t              fwd_out_word_mask,
    output logic                    full,
    output logic                    empty,
    output logic [FWD_STALL_BITS:0] count
);

    fwd_stall_entry_t            ent_r [N_FWD_STALL];
    logic [FWD_STALL_BITS:0]     count_r;
    logic                        lock_r;
    logic [FWD_STALL_BITS-1:0]   lock_idx_r;
    logic                        full_r;
    logic                        empty_r;
    mix_msg_t                    out_coh_msg_r;
    line_addr_t                  out_addr_r;
    cache_id_t                   out_req_id_r;
    word_mask_t                  out_word_mask_r;

    logic                        push_s;
    logic                        pop_s;
    logic                        sel_found_s;
    logic [FWD_STALL_BITS-1:0]   sel_idx_s;
    logic [FWD_STALL_BITS:0]     count_kept_s;
    logic [FWD_STALL_BITS:0]     count_nxt_s;
    fwd_stall_entry_t            new_ent_s;
    fwd_stall_entry_t            ent_nxt_s [N_FWD_STALL];

    // Ready reflects the registered full flag only; no bypass on a pop.
    assign push_s = fwd_in_valid && !full_r;
    assign pop_s  = lock_r && fwd_out_ready;

    assign fwd_in_ready      = !full_r;
    assign fwd_out_valid     = lock_r;
    assign fwd_out_coh_msg   = out_coh_msg_r;
    assign fwd_out_addr      = out_addr_r;
    assign fwd_out_req_id    = out_req_id_r;
    assign fwd_out_word_mask = out_word_mask_r;
    assign full              = full_r;
    assign empty             = empty_r;
    assign count             = count_r;

    // Oldest-ready picker. A done arriving this cycle counts as already
    // released so the entry can lock at the very next edge.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = N_FWD_STALL - 1; i >= 0; i--) begin
            if ((i < int'(count_r)) &&
                !(ent_r[i].pending &&
                  !done_hit(ent_r[i].wait_i, req_done_valid, req_done_i))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = FWD_STALL_BITS'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Incoming entry; a done for its wait index in the same cycle enters it released.
    always_comb begin
        new_ent_s.coh_msg   = fwd_in_coh_msg;
        new_ent_s.addr      = fwd_in_addr;
        new_ent_s.req_id    = fwd_in_req_id;
        new_ent_s.word_mask = fwd_in_word_mask;
        new_ent_s.wait_i    = fwd_in_wait_i;
        new_ent_s.pending   = !done_hit(fwd_in_wait_i, req_done_valid, req_done_i);
    end

    // Next array: compact over the popped slot, apply done, then append the push.
    always_comb begin
        if (pop_s) begin
            count_kept_s = count_r - {{FWD_STALL_BITS{1'b0}}, 1'b1};
        end else begin
            count_kept_s = count_r;
        end
        count_nxt_s = count_kept_s + {{FWD_STALL_BITS{1'b0}}, push_s};
        for (int i = 0; i < N_FWD_STALL; i++) begin
            if (pop_s && (i >= int'(lock_idx_r))) begin
                if (i < N_FWD_STALL - 1) begin
                    ent_nxt_s[i] = ent_r[(i + 1) % N_FWD_STALL];
                end else begin
                    ent_nxt_s[i] = '0;
                end
            end else begin
                ent_nxt_s[i] = ent_r[i];
            end
            if (i >= int'(count_kept_s)) begin
                ent_nxt_s[i] = '0;
            end else begin
                ent_nxt_s[i].pending = ent_nxt_s[i].pending &&
                    !done_hit(ent_nxt_s[i].wait_i, req_done_valid, req_done_i);
            end
            if (push_s && (i == int'(count_kept_s))) begin
                ent_nxt_s[i] = new_ent_s;
            end else begin
                ent_nxt_s[i] = ent_nxt_s[i];
            end
        end
    end

    // Storage, occupancy flags, lock and registered replay fields.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_FWD_STALL; i++) begin
                ent_r[i] <= '0;
            end
            count_r         <= '0;
            full_r          <= 1'b0;
            empty_r         <= 1'b1;
            lock_r          <= 1'b0;
            lock_idx_r      <= '0;
            out_coh_msg_r   <= '0;
            out_addr_r      <= '0;
            out_req_id_r    <= '0;
            out_word_mask_r <= '0;
        end else begin
            for (int i = 0; i < N_FWD_STALL; i++) begin
                ent_r[i] <= ent_nxt_s[i];
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == (FWD_STALL_BITS+1)'(N_FWD_STALL));
            empty_r <= (count_nxt_s == {(FWD_STALL_BITS+1){1'b0}});
            if (pop_s) begin
                lock_r <= 1'b0;
            end else if (!lock_r && sel_found_s) begin
                // No pop and no lock means no compaction: sel_idx_s stays valid.
                lock_r          <= 1'b1;
                lock_idx_r      <= sel_idx_s;
                out_coh_msg_r   <= ent_r[sel_idx_s].coh_msg;
                out_addr_r      <= ent_r[sel_idx_s].addr;
                out_req_id_r    <= ent_r[sel_idx_s].req_id;
                out_word_mask_r <= ent_r[sel_idx_s].word_mask;
            end else begin
                lock_r <= lock_r;
            end
        end
    end

endmodule
